// File: rtl/cpu_dout_receiver.sv
// Output-port receiver: captures reg_dout on enable && reg_gout[7] into a small FIFO drained by ready/valid.
// Optional repeat filter enabled by defining CPU_RX_DEDUP_EN.
module cpu_dout_receiver #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         reg_dout,
    input  logic [7:0]               reg_gout,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             cap;
    logic             full;
    logic             push;
    logic             pop;
    logic             unused_gout;

    assign unused_gout = ^reg_gout[6:0];

`ifdef CPU_RX_DEDUP_EN
    logic             primed;
    logic [WIDTH-1:0] last;

    assign cap = enable && reg_gout[7] && (!primed || (reg_dout != last));

    // The filter only learns from bytes that actually entered the FIFO, so a dropped byte is retried.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed <= 1'b0;
            last   <= '0;
        end else if (push) begin
            primed <= 1'b1;
            last   <= reg_dout;
        end
    end
`else
    assign cap = enable && reg_gout[7];
`endif

    always_comb begin
        full        = (fifo_count == CW'(DEPTH));
        pop         = out_valid && out_ready;
        push        = cap && (!full || pop);
        rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;
        count_next  = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CW'(1);
        end
        // A byte written into the slot that becomes the head must bypass the array read.
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = reg_dout;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= reg_dout;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_ptr_next;
            fifo_count <= count_next;
            out_valid  <= (count_next != '0);
            out_data   <= head_next;
            if (cap && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cpu_dout_receiver.md
# cpu_dout_receiver

Receiving end of the CPU's output port. Samples the CPU's `reg_dout` byte whenever the CPU advances (`enable`) with data-valid (`reg_gout[7]`) asserted, optionally filters out repeats, and buffers accepted bytes in a small FIFO. It presents them downstream (display/serial driver) over a ready/valid handshake. It sits between the `cpu` instance and any output peripheral, on the same clock and `enable` strobe as the CPU.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `WIDTH`, 8, data width; must match `reg_dout`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  CPU step strobe (same signal that advances `instruction_pointer`).
- `reg_dout`  in  WIDTH  CPU output data.
- `reg_gout`  in  8  CPU general outputs; bit 7 = dval.
- `out_data`  out  WIDTH  FIFO head byte.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a capture was dropped because the FIFO was full.

## Operation
- Capture condition (`cap`): `enable && reg_gout[7]` (further gated by the dedup filter when `CPU_RX_DEDUP_EN` is defined).
- Push: `cap && (!full || pop)`. Writes `reg_dout` at the write pointer; wr_ptr increments mod DEPTH.
- Pop: `out_valid && out_ready`. rd_ptr increments mod DEPTH.
- Pointers wrap naturally at DEPTH. `fifo_count` changes +1 on push only, −1 on pop only, and is unchanged on both.
- Full with `cap` and no pop: byte dropped, `overflow` set to 1. It clears only on reset. Pointers and count are unchanged.
- Full with `cap` and pop in the same cycle: the push is accepted, `fifo_count` stays DEPTH, and `overflow` is not set.
- Empty with `cap`: no fall-through. The byte appears on `out_data` and `out_valid` rises on the next cycle.
- `out_ready` while empty: ignored.
- `enable` low: no capture, whatever `reg_gout[7]` is. Pops continue independently of `enable`.
- `out_data` holds the head entry whenever `out_valid` = 1. It is don't-care while empty but must not contain X after reset; storage is reset to 0.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `fifo_count` 0, `overflow` 0, pointers 0, dedup state = unprimed with last = 0.
- Reset is asynchronous assert; outputs go to reset values immediately. Reset mid-operation discards all buffered bytes.
- Push-to-`out_valid` latency: 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- `out_valid`, `fifo_count` and `overflow` are registered; none is a combinational function of the current-cycle inputs.
- `out_data` is the registered read of the head entry and is updated in the same edge as rd_ptr.
- Downstream must hold `out_ready` independent of `out_valid`. There is no combinational path from `out_ready` to `out_valid`.

## Configuration
- Macro: `CPU_RX_DEDUP_EN`.
- Defined:
  - An extra condition gates `cap`: the block is unprimed, or `reg_dout != last`.
  - `last` and primed are updated only on an accepted push.
  - A dropped (overflow) byte is therefore retried on the next qualifying cycle with the same value.
  - Effect: a CPU that holds `reg_dout` constant produces exactly one FIFO entry per distinct value.
- Undefined: every `enable && reg_gout[7]` cycle is a capture. No `last` register or primed flag is implemented.

## Test plan
- Reset then idle: assert `reset` mid-cycle. Required: outputs go to 0 asynchronously, `fifo_count` = 0 and `out_valid` = 0 after release.
- Basic capture: `enable` = 1, `reg_gout` = 8'h80, `reg_dout` = 8'h12, 8'h34, 8'h56 on successive cycles, `out_ready` = 0. Required: `fifo_count` = 3. Then with `out_ready` = 1: `out_data` = 12, 34, 56 in order, then `out_valid` = 0.
- Overflow (DEPTH = 4, dedup off): 5 captures of 8'hA0..A4 with `out_ready` = 0. Required: `fifo_count` = 4, `overflow` = 1, drain yields A0..A3 only. `overflow` stays 1 until reset.
- Full with simultaneous push/pop: fill with 1..4, then one cycle of capture 8'h05 with `out_ready` = 1. Required: `fifo_count` stays 4, `overflow` = 0, drain yields 2, 3, 4, 5.
- Gating: `reg_gout` = 8'h00 with `enable` = 1, then `reg_gout` = 8'h80 with `enable` = 0, 10 cycles each. Required: `fifo_count` = 0 throughout.
- Dedup (`CPU_RX_DEDUP_EN` defined): `reg_dout` = 8'h07 held for 8 enabled cycles, then 8'h09 for 3. Required: `fifo_count` = 2 with contents 07, 09. With the macro undefined, the same stimulus gives 4 entries and `overflow` = 1 (DEPTH = 4).
